// File: rtl/tkm_pkg.sv
// Shared definitions for the bit-serial subtractor tile.
package tkm_pkg;

  // Operand and result width; fixed by the tile pin budget.
  localparam int WIDTH = 8;

  // Controller states. Names carry an ST_ prefix so the DONE state does not
  // collide with the DONE status-bit index below.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions on the bidirectional pins.
  localparam int LOAD_A = 0;
  localparam int LOAD_B = 1;
  localparam int START  = 2;
  localparam int BUSY   = 4;
  localparam int DONE   = 5;
  localparam int BORROW = 6;

  // Only the three status pins are driven as outputs.
  localparam logic [7:0] UIO_OE_MASK = 8'h70;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: the per-bit datapath of the serial subtractor.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out for a - b - bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/tt_um_tkm_serial_sub.sv
// Tiny Tapeout tile: LSB-first bit-serial 8-bit subtractor (A - B mod 256).
module tt_um_tkm_serial_sub
  import tkm_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] result;
  logic             br;
  logic             borrow_flag;
  logic [CW-1:0]    cnt;

  logic load_a;
  logic load_b;
  logic start;
  logic d;
  logic bout;
  logic last;

  // ena and the upper control bits carry no function in this tile.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  assign load_a = uio_in[LOAD_A];
  assign load_b = uio_in[LOAD_B];
  assign start  = uio_in[START];
  assign last   = (cnt == LAST_BIT);

  full_sub_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: start launches from IDLE/DONE, RUN ends after the last bit.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (last)  next_state = ST_DONE;
      ST_DONE: if (start) next_state = ST_RUN;
      default:            next_state = ST_IDLE;
    endcase
  end

  // Datapath: operand loading, per-bit shifting and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      diff_sh     <= '0;
      result      <= '0;
      br          <= 1'b0;
      borrow_flag <= 1'b0;
      cnt         <= '0;
    end else if (state == ST_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= {d, diff_sh[WIDTH-1:1]};
      br      <= bout;
      if (last) begin
        cnt         <= '0;
        result      <= {d, diff_sh[WIDTH-1:1]};
        borrow_flag <= bout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (start) begin
      cnt <= '0;
      br  <= 1'b0;
    end else begin
      if (load_a) a_sh <= ui_in;
      if (load_b) b_sh <= ui_in;
    end
  end

  // Output pins: result register plus busy/done/borrow status.
  always_comb begin
    uio_out         = '0;
    uio_out[BUSY]   = (state == ST_RUN);
    uio_out[DONE]   = (state == ST_DONE);
    uio_out[BORROW] = borrow_flag;
    uo_out          = result;
    uio_oe          = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_tt_um_tkm_serial_sub.sv
// Self-checking bench for the bit-serial subtractor tile.
module tb_tt_um_tkm_serial_sub;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int vectors;
  int miscompares;
  logic [7:0] last_result;
  logic       last_borrow;

  tt_um_tkm_serial_sub dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: unsigned difference modulo 256 and borrow when A < B.
  function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
    int v;
    v = int'(a) - int'(b);
    if (v < 0) v = v + 256;
    return 8'(v);
  endfunction

  function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
    return int'(a) < int'(b);
  endfunction

  // Stimulus: load both operands, leaving the bench at a falling edge.
  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    uio_in = 8'h01; ui_in = a;
    @(negedge clk);
    uio_in = 8'h02; ui_in = b;
    @(negedge clk);
    uio_in = 8'h00; ui_in = 8'h00;
  endtask

  // Stimulus: strobe start for one edge; returns at the falling edge after edge k.
  task automatic pulse_start(input logic [7:0] extra, input logic [7:0] data);
    uio_in = 8'h04 | extra; ui_in = data;
    @(negedge clk);
    uio_in = 8'h00; ui_in = 8'h00;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h70) begin
      miscompares++;
      $display("[TB] FAIL reset: uo_out=%h uio_out=%h uio_oe=%h, want 00 00 70", uo_out, uio_out, uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h70) begin
      miscompares++;
      $display("[TB] FAIL post_reset: uo_out=%h uio_out=%h uio_oe=%h, want 00 00 70", uo_out, uio_out, uio_oe);
    end
    last_result = 8'h00;
    last_borrow = 1'b0;
  endtask

  // Full operation with per-cycle busy/hold checks and final result check.
  task automatic test_op(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] exp_d;
    logic       exp_b;
    exp_d = ref_diff(a, b);
    exp_b = ref_borrow(a, b);
    load_ops(a, b);
    vectors++;
    if (uo_out !== last_result) begin
      miscompares++;
      $display("[TB] FAIL %s load_hold: uo_out=%0d, want %0d", name, uo_out, last_result);
    end
    pulse_start(8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (uio_out[4] !== 1'b1 || uio_out[5] !== 1'b0 || uo_out !== last_result) begin
        miscompares++;
        $display("[TB] FAIL %s run_cycle%0d: busy=%b done=%b uo_out=%0d, want 1 0 %0d",
                 name, i, uio_out[4], uio_out[5], uo_out, last_result);
      end
      @(negedge clk);
    end
    vectors++;
    if (uo_out !== exp_d || uio_out !== {1'b0, exp_b, 6'b100000}) begin
      miscompares++;
      $display("[TB] FAIL %s result: uo_out=%0d uio_out=%b, want %0d %b",
               name, uo_out, uio_out, exp_d, {1'b0, exp_b, 6'b100000});
    end
    last_result = exp_d;
    last_borrow = exp_b;
  endtask

  task automatic test_boundaries;
    test_op("zero_minus_zero", 8'd0, 8'd0);
    test_op("ff_minus_ff", 8'd255, 8'd255);
    test_op("zero_minus_one", 8'd0, 8'd1);
    test_op("ff_minus_zero", 8'd255, 8'd0);
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_b;
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp_d = ref_diff(a, b);
      exp_b = ref_borrow(a, b);
      load_ops(a, b);
      pulse_start(8'h00, 8'h00);
      repeat (8) @(negedge clk);
      vectors++;
      if (uo_out !== exp_d || uio_out[6] !== exp_b || uio_out[5] !== 1'b1 || uio_out[4] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL random %0d-%0d: uo_out=%0d borrow=%b done=%b busy=%b, want %0d %b 1 0",
                 a, b, uo_out, uio_out[6], uio_out[5], uio_out[4], exp_d, exp_b);
      end
      last_result = exp_d;
      last_borrow = exp_b;
    end
  endtask

  // Loads and start pulsed mid-RUN must not disturb the running operation.
  task automatic test_run_ignore;
    load_ops(8'd200, 8'd55);
    pulse_start(8'h00, 8'h00);
    @(negedge clk);
    uio_in = 8'h07; ui_in = 8'hFF;
    @(negedge clk);
    uio_in = 8'h00; ui_in = 8'h00;
    repeat (6) @(negedge clk);
    vectors++;
    if (uo_out !== 8'd145 || uio_out[6] !== 1'b0 || uio_out[5] !== 1'b1 || uio_out[4] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL run_ignore: uo_out=%0d borrow=%b done=%b busy=%b, want 145 0 1 0",
               uo_out, uio_out[6], uio_out[5], uio_out[4]);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (uio_out[4] !== 1'b0 || uio_out[5] !== 1'b1 || uo_out !== 8'd145) begin
      miscompares++;
      $display("[TB] FAIL no_restart: busy=%b done=%b uo_out=%0d, want 0 1 145", uio_out[4], uio_out[5], uo_out);
    end
    last_result = 8'd145;
    last_borrow = 1'b0;
  endtask

  // Start wins over a simultaneous load_b.
  task automatic test_start_with_load;
    load_ops(8'd20, 8'd10);
    pulse_start(8'h02, 8'd50);
    repeat (8) @(negedge clk);
    vectors++;
    if (uo_out !== 8'd10 || uio_out[6] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_with_load: uo_out=%0d borrow=%b, want 10 0", uo_out, uio_out[6]);
    end
    last_result = 8'd10;
    last_borrow = 1'b0;
  endtask

  // Asynchronous reset in the middle of RUN aborts the operation.
  task automatic test_reset_mid_run;
    load_ops(8'd9, 8'd200);
    pulse_start(8'h00, 8'h00);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h70) begin
      miscompares++;
      $display("[TB] FAIL mid_run_reset: uo_out=%h uio_out=%h uio_oe=%h, want 00 00 70", uo_out, uio_out, uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL after_reset_idle: uio_out=%b uo_out=%0d, want 00000000 0", uio_out, uo_out);
    end
    last_result = 8'h00;
    last_borrow = 1'b0;
    test_op("seven_minus_three", 8'd7, 8'd3);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ena         = 1'b1;
    ui_in       = 8'h00;
    uio_in      = 8'h00;
    rst_n       = 1'b1;
    test_reset();
    test_op("basic_100_37", 8'd100, 8'd37);
    test_op("borrow_5_9", 8'd5, 8'd9);
    test_boundaries();
    test_random();
    test_run_ignore();
    test_start_with_load();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
